mmu_pmp_pte_check: RTL and testbench
====================================

# mmu_pmp_pte_check

Synchronous PMP checker for the page-table walker's PTE-address requests (the PMP0 stage). It consumes the 48-bit PTE-read request the PTW emits on its PMP0 output and walks the PMP entries sequentially, one entry per cycle, with lowest index having priority. A permitted request is forwarded unchanged to the dcache. A denied request becomes an access-fault packet for the IFU or LSU exception unit.

## Interface
- PMP_ENTRIES, 4: number of implemented PMP entries (1..16).
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_ptw_pmp0_drive_1  in  1  request valid from PTW.
- o_pmp0_ptw_free_1  out  1  ready to PTW.
- i_ptw_pmp0_data_48  in  48  {l1tlbIndex[47:44], reqIndex[43:38], pteAddr[37:4], cpuMode[3:2], reqType[1:0]}.
- o_pmp0_dcache_drive_1  out  1  permitted request valid.
- i_dcache_pmp0_free_1  in  1  dcache ready.
- o_pmp0_dcache_data_48  out  48  accepted request, bit-identical.
- o_pmp0_ifuexp_drive_1  out  1  fetch-side fault valid.
- i_ifuexp_pmp0_free_1  in  1  IFU exception unit ready.
- o_pmp0_ifuexp_data_5  out  5  fault cause.
- o_pmp0_lsuexp_drive_1  out  1  load/store-side fault valid.
- i_lsuexp_pmp0_free_1  in  1  LSU exception unit ready.
- o_pmp0_lsuexp_data_11  out  11  {reqIndex, cause}.
- i_csr_pmpcfg_we_1  in  1  write pmpcfg[idx] with wdata[7:0].
- i_csr_pmpaddr_we_1  in  1  write pmpaddr[idx] with wdata.
- i_csr_pmp_idx_4  in  4  entry index; an index ≥ PMP_ENTRIES is ignored.
- i_csr_pmp_wdata_32  in  32  write data.

## Operation
- **Handshake.** A drive/free pair transfers on a rising edge where both are high.
  - Drive is held high until the transfer, and data is held stable while drive is high.
  - o_pmp0_ptw_free_1 is high only in IDLE.
- **States.**
  - IDLE: on accept, latch the 48-bit request, set idx=0, go to CHECK.
  - CHECK: evaluate entry idx each edge. On a match, or when idx=PMP_ENTRIES-1, record the verdict and go to RESP. Otherwise idx++.
  - RESP: assert exactly one output drive. After its transfer, go to IDLE.
- **pmpcfg fields.** R=[0], W=[1], X=[2], A=[4:3] (00 OFF, 01 TOR, 10 NA4, 11 NAPOT), L=[7]. The address word is a=pteAddr[33:2] (32b).
- **Matching rules.**
  - OFF: never matches.
  - TOR: pmpaddr[i-1] ≤ a < pmpaddr[i], with a lower bound of 0 for entry 0. Comparisons are unsigned 32b.
  - NA4: a == pmpaddr[i].
  - NAPOT: ((a ^ pmpaddr[i]) & ~(pmpaddr[i] ^ (pmpaddr[i]+1))) == 0. The +1 is 32b and wraps.
- **Verdict.** A PTE fetch is always a read, so R is the permission checked.
  - Matched, M-mode (cpuMode=11): allow if L=0; otherwise allow iff R.
  - Matched, S/U mode: allow iff R.
  - No match: allow in M-mode, deny otherwise.
- **Deny routing.**
  - reqType[1]=0: ifuexp, data 5'd1.
  - reqType=10: lsuexp, data {reqIndex, 5'd5}.
  - reqType=11: lsuexp, data {reqIndex, 5'd7}.
  - Undriven data outputs are 0.
- **CSR writes.**
  - Writes are accepted in any state.
  - A write to entry i is ignored if cfg[i].L=1.
  - A pmpaddr[i-1] write is also ignored if cfg[i].L=1 and cfg[i].A=TOR.
  - Simultaneous cfg and addr writes both apply.
  - CHECK uses the register values present at each entry's evaluation edge.

## Timing
- **Reset.** All drives 0, all data outputs 0, o_pmp0_ptw_free_1=1, state IDLE, all pmpcfg/pmpaddr 0.
  - Reset asserted mid-CHECK or mid-RESP aborts the request; nothing is emitted afterwards.
- **Latency.** Let acceptance be edge E0.
  - A match at entry k sets output drive visible after edge E0+k+1.
  - No match: visible after E0+PMP_ENTRIES.
  - Free returns high the cycle after the output transfer edge.
- **Throughput.** Back-to-back requests are not overlapped; at most one request is in flight.
- **Backpressure.** In RESP with the consumer's free low, drive and data are held indefinitely.

## Test plan
- Entry0 cfg=0x19 (NAPOT,R), pmpaddr0=0x00001FFF; S-mode load, pteAddr=0x0_0000_1000 -> dcache drive after E0+1, data equal to input.
- Same config, S-mode store, pteAddr=0x0_0002_0000 -> no match, lsuexp drive after E0+4, data {reqIndex,5'd7}. Same request in M-mode -> dcache drive after E0+4.
- TOR check:
  - Setup: pmpaddr0=0x1FFF with cfg0 OFF; cfg1=0x0B (TOR,R,W); pmpaddr1=0x10000.
  - Stimulus: pteAddr=0x0_0003_0000, U-mode load.
  - Expected: match at entry1, dcache drive after E0+2.
- Lock check:
  - Setup: cfg2=0x98 (L,NAPOT,no R) covering the address.
  - M-mode fetch (reqType=00) -> ifuexp drive, data 5'd1.
  - A subsequent write of 0x00 to cfg2 -> cfg2 still 0x98.
- Backpressure: hold the dcache free low for 3 cycles in RESP -> drive and data stable, PTW free stays 0; transfer on the 4th edge, then PTW free=1.
- Reset asserted during CHECK -> all drives 0 and free=1 immediately; no output packet after reset is released.

Source files
------------

// File: rtl/mmu_pmp_pte_check.sv
// PMP0 stage: sequential PMP check of page-table-walker PTE reads.
// Permitted requests go to the dcache; denied ones become IFU/LSU faults.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   i_ptw_pmp0_drive_1/_data_48    request from PTW
//   o_pmp0_ptw_free_1              ready to PTW (IDLE only)
//   o_pmp0_dcache_drive_1/_data_48 permitted request, i_dcache_pmp0_free_1 ready
//   o_pmp0_ifuexp_drive_1/_data_5  fetch fault, i_ifuexp_pmp0_free_1 ready
//   o_pmp0_lsuexp_drive_1/_data_11 load/store fault, i_lsuexp_pmp0_free_1 ready
//   i_csr_pmp*                     pmpcfg/pmpaddr write port
module mmu_pmp_pte_check #(
  parameter int PMP_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_ptw_pmp0_drive_1,
  output logic        o_pmp0_ptw_free_1,
  input  logic [47:0] i_ptw_pmp0_data_48,
  output logic        o_pmp0_dcache_drive_1,
  input  logic        i_dcache_pmp0_free_1,
  output logic [47:0] o_pmp0_dcache_data_48,
  output logic        o_pmp0_ifuexp_drive_1,
  input  logic        i_ifuexp_pmp0_free_1,
  output logic [4:0]  o_pmp0_ifuexp_data_5,
  output logic        o_pmp0_lsuexp_drive_1,
  input  logic        i_lsuexp_pmp0_free_1,
  output logic [10:0] o_pmp0_lsuexp_data_11,
  input  logic        i_csr_pmpcfg_we_1,
  input  logic        i_csr_pmpaddr_we_1,
  input  logic [3:0]  i_csr_pmp_idx_4,
  input  logic [31:0] i_csr_pmp_wdata_32
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(PMP_ENTRIES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cfg   [16];
  logic [31:0] paddr [16];
  logic [47:0] req;
  logic [3:0]  idx;
  logic        allow;

  logic [31:0] a;
  logic        m_mode;
  logic [7:0]  cur_cfg;
  logic [31:0] cur_addr;
  logic [31:0] lo_addr;
  logic [31:0] napot_mask;
  logic        hit;
  logic        done;
  logic        verdict;
  logic        accept;
  logic        out_fire;
  logic [16:0] tor_lock;
  logic        unused_cfg;

  assign a      = req[37:6];
  assign m_mode = &req[3:2];
  assign accept = (state == IDLE) & i_ptw_pmp0_drive_1;

  // Entry under evaluation this cycle.
  assign cur_cfg    = cfg[idx];
  assign cur_addr   = paddr[idx];
  assign lo_addr    = (idx == 4'd0) ? 32'd0 : paddr[idx - 4'd1];
  assign napot_mask = ~(cur_addr ^ (cur_addr + 32'd1));
  assign unused_cfg = ^cur_cfg[6:5];

  always_comb begin
    hit = 1'b0;
    unique case (cur_cfg[4:3])
      2'b01:   hit = (a >= lo_addr) && (a < cur_addr);
      2'b10:   hit = (a == cur_addr);
      2'b11:   hit = ((a ^ cur_addr) & napot_mask) == 32'd0;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    if (hit)
      verdict = m_mode ? (~cur_cfg[7] | cur_cfg[0]) : cur_cfg[0];
    else
      verdict = m_mode;
  end

  assign done = hit | (idx == LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_ptw_pmp0_drive_1) state_nxt = CHECK;
      CHECK:   if (done) state_nxt = RESP;
      RESP:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_pmp0_ptw_free_1     = (state == IDLE);
    o_pmp0_dcache_drive_1 = 1'b0;
    o_pmp0_dcache_data_48 = '0;
    o_pmp0_ifuexp_drive_1 = 1'b0;
    o_pmp0_ifuexp_data_5  = '0;
    o_pmp0_lsuexp_drive_1 = 1'b0;
    o_pmp0_lsuexp_data_11 = '0;
    if (state == RESP) begin
      if (allow) begin
        o_pmp0_dcache_drive_1 = 1'b1;
        o_pmp0_dcache_data_48 = req;
      end else if (!req[1]) begin
        o_pmp0_ifuexp_drive_1 = 1'b1;
        o_pmp0_ifuexp_data_5  = 5'd1;
      end else begin
        o_pmp0_lsuexp_drive_1 = 1'b1;
        o_pmp0_lsuexp_data_11 = {req[43:38], req[0] ? 5'd7 : 5'd5};
      end
    end
  end

  assign out_fire =
    (o_pmp0_dcache_drive_1 & i_dcache_pmp0_free_1) |
    (o_pmp0_ifuexp_drive_1 & i_ifuexp_pmp0_free_1) |
    (o_pmp0_lsuexp_drive_1 & i_lsuexp_pmp0_free_1);

  // Request datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req   <= '0;
      idx   <= '0;
      allow <= 1'b0;
    end else if (accept) begin
      req <= i_ptw_pmp0_data_48;
      idx <= '0;
    end else if (state == CHECK) begin
      if (done) allow <= verdict;
      else      idx   <= idx + 4'd1;
    end
  end

  // A locked TOR entry also freezes the address below it.
  always_comb begin
    tor_lock = '0;
    for (int i = 0; i < 16; i++)
      tor_lock[i] = (i < PMP_ENTRIES) && cfg[i][7] &&
                    (cfg[i][4:3] == 2'b01);
  end

  // CSR write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        cfg[i]   <= '0;
        paddr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if ((i < PMP_ENTRIES) && (i_csr_pmp_idx_4 == 4'(i))) begin
          if (i_csr_pmpcfg_we_1 && !cfg[i][7])
            cfg[i] <= i_csr_pmp_wdata_32[7:0];
          if (i_csr_pmpaddr_we_1 && !cfg[i][7] && !tor_lock[i+1])
            paddr[i] <= i_csr_pmp_wdata_32;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu_pmp_pte_check.sv
// Bench for mmu_pmp_pte_check: directed vector table plus
// hand-written backpressure, lock and reset sequences.
module tb_mmu_pmp_pte_check;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ptw_drive = 1'b0;
  logic        ptw_free;
  logic [47:0] ptw_data = '0;
  logic        dc_drive;
  logic        dc_free = 1'b1;
  logic [47:0] dc_data;
  logic        ifu_drive;
  logic        ifu_free = 1'b1;
  logic [4:0]  ifu_data;
  logic        lsu_drive;
  logic        lsu_free = 1'b1;
  logic [10:0] lsu_data;
  logic        cfg_we = 1'b0;
  logic        addr_we = 1'b0;
  logic [3:0]  csr_idx = '0;
  logic [31:0] csr_wdata = '0;

  int total = 0;
  int bad = 0;

  mmu_pmp_pte_check #(.PMP_ENTRIES(4)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_ptw_pmp0_drive_1    (ptw_drive),
    .o_pmp0_ptw_free_1     (ptw_free),
    .i_ptw_pmp0_data_48    (ptw_data),
    .o_pmp0_dcache_drive_1 (dc_drive),
    .i_dcache_pmp0_free_1  (dc_free),
    .o_pmp0_dcache_data_48 (dc_data),
    .o_pmp0_ifuexp_drive_1 (ifu_drive),
    .i_ifuexp_pmp0_free_1  (ifu_free),
    .o_pmp0_ifuexp_data_5  (ifu_data),
    .o_pmp0_lsuexp_drive_1 (lsu_drive),
    .i_lsuexp_pmp0_free_1  (lsu_free),
    .o_pmp0_lsuexp_data_11 (lsu_data),
    .i_csr_pmpcfg_we_1     (cfg_we),
    .i_csr_pmpaddr_we_1    (addr_we),
    .i_csr_pmp_idx_4       (csr_idx),
    .i_csr_pmp_wdata_32    (csr_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] DC  = 3'b001;
  localparam logic [2:0] IFU = 3'b010;
  localparam logic [2:0] LSU = 3'b100;

  typedef struct {
    logic [47:0] data;
    int          lat;
    logic [2:0]  dest;
  } vec_t;

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [3:0] l1,
    input logic [5:0] ri, input logic [33:0] pte,
    input logic [1:0] md, input logic [1:0] ty);
    return {l1, ri, pte, md, ty};
  endfunction

  // Expected {dcache, ifuexp, lsuexp} data for a given destination.
  function automatic logic [63:0] exp_of(input logic [47:0] d,
                                         input logic [2:0] dest);
    logic [63:0] r;
    r = '0;
    if (dest == DC)  r = {d, 16'h0};
    if (dest == IFU) r = {48'h0, 5'd1, 11'h0};
    if (dest == LSU) r = {53'h0, d[43:38], d[0] ? 5'd7 : 5'd5};
    return r;
  endfunction

  task automatic csr(input logic cw, input logic aw,
                     input logic [3:0] i, input logic [31:0] w);
    @(posedge clk); #1;
    cfg_we = cw; addr_we = aw; csr_idx = i; csr_wdata = w;
    @(posedge clk); #1;
    cfg_we = 1'b0; addr_we = 1'b0;
  endtask

  task automatic run_req(input string nm, input logic [47:0] d,
                         input int lat, input logic [2:0] dest,
                         input int hold);
    int cyc;
    logic [63:0] ex;
    ex = exp_of(d, dest);
    @(posedge clk); #1;
    {dc_free, ifu_free, lsu_free} = (hold == 0) ? 3'b111 : 3'b000;
    chk($sformatf("%s:free_idle", nm), 128'(ptw_free), 128'(1));
    ptw_drive = 1'b1;
    ptw_data  = d;
    @(posedge clk); #1;
    ptw_drive = 1'b0;
    ptw_data  = '0;
    chk($sformatf("%s:free_busy", nm), 128'(ptw_free), 128'(0));
    cyc = 1;
    while (cyc <= 12) begin
      @(posedge clk); #1;
      if (dc_drive | ifu_drive | lsu_drive) break;
      cyc++;
    end
    chk($sformatf("%s:latency", nm), 128'(cyc), 128'(lat));
    chk($sformatf("%s:dest", nm),
        128'({lsu_drive, ifu_drive, dc_drive}), 128'(dest));
    chk($sformatf("%s:data", nm),
        128'({dc_data, ifu_data, lsu_data}), 128'(ex));
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      chk($sformatf("%s:hold%0d", nm, j),
          128'({lsu_drive, ifu_drive, dc_drive,
                dc_data, ifu_data, lsu_data, ptw_free}),
          128'({dest, ex, 1'b0}));
    end
    {dc_free, ifu_free, lsu_free} = 3'b111;
    @(posedge clk); #1;
    chk($sformatf("%s:after", nm),
        128'({ptw_free, lsu_drive, ifu_drive, dc_drive}),
        128'(4'b1000));
  endtask

  vec_t vt [13];

  initial begin
    int seen;

    vt[0]  = '{mk(4'd1,  6'h01, 34'h0_0000_1000, 2'b01, 2'b10), 1, DC};
    vt[1]  = '{mk(4'd2,  6'h02, 34'h0_0000_FFFF, 2'b00, 2'b00), 1, DC};
    vt[2]  = '{mk(4'd3,  6'h03, 34'h0_0001_0000, 2'b01, 2'b10), 4, LSU};
    vt[3]  = '{mk(4'd4,  6'h04, 34'h0_0001_4000, 2'b00, 2'b11), 2, LSU};
    vt[4]  = '{mk(4'd5,  6'h05, 34'h0_0001_4000, 2'b11, 2'b10), 2, DC};
    vt[5]  = '{mk(4'd6,  6'h06, 34'h0_0001_4004, 2'b01, 2'b10), 3, DC};
    vt[6]  = '{mk(4'd7,  6'h07, 34'h0_0003_FFFC, 2'b01, 2'b10), 3, DC};
    vt[7]  = '{mk(4'd8,  6'h08, 34'h0_0004_0000, 2'b01, 2'b01), 4, IFU};
    vt[8]  = '{mk(4'd9,  6'h09, 34'h0_0020_0000, 2'b00, 2'b10), 4, LSU};
    vt[9]  = '{mk(4'd10, 6'h0A, 34'h0_0020_0000, 2'b11, 2'b11), 4, DC};
    vt[10] = '{mk(4'd11, 6'h0B, 34'h0_0001_3FFC, 2'b01, 2'b00), 4, IFU};
    vt[11] = '{mk(4'd12, 6'h3F, 34'h3_FFFF_FFFF, 2'b00, 2'b10), 4, LSU};
    vt[12] = '{mk(4'd13, 6'h0C, 34'h0_0001_0000, 2'b11, 2'b00), 4, DC};

    #12;
    chk("reset_out",
        128'({ptw_free, dc_drive, ifu_drive, lsu_drive,
              dc_data, ifu_data, lsu_data}),
        128'({1'b1, 3'b000, 64'h0}));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Table config: NAPOT R / NA4 no-R / TOR RW / NAPOT no-R
    csr(1, 0, 0, 32'h19);  csr(0, 1, 0, 32'h0000_1FFF);
    csr(1, 0, 1, 32'h10);  csr(0, 1, 1, 32'h0000_5000);
    csr(1, 0, 2, 32'h0B);  csr(0, 1, 2, 32'h0001_0000);
    csr(1, 0, 3, 32'h18);  csr(0, 1, 3, 32'h0003_FFFF);
    for (int i = 0; i < 13; i++)
      run_req($sformatf("vec%0d", i), vt[i].data, vt[i].lat,
              vt[i].dest, 0);

    // Only entry0 active
    csr(1, 0, 1, 32'h0); csr(1, 0, 2, 32'h0); csr(1, 0, 3, 32'h0);
    run_req("napot_s_load",
      mk(4'd1, 6'h15, 34'h0_0000_1000, 2'b01, 2'b10), 1, DC, 0);
    run_req("nomatch_s_store",
      mk(4'd2, 6'h2A, 34'h0_0002_0000, 2'b01, 2'b11), 4, LSU, 0);
    run_req("nomatch_m_store",
      mk(4'd3, 6'h2A, 34'h0_0002_0000, 2'b11, 2'b11), 4, DC, 0);

    // TOR at entry1 above an OFF entry0
    csr(1, 0, 0, 32'h0);
    csr(0, 1, 1, 32'h0001_0000);
    csr(1, 0, 1, 32'h0B);
    run_req("tor_u_load",
      mk(4'd4, 6'h11, 34'h0_0003_0000, 2'b00, 2'b10), 2, DC, 0);
    run_req("backpressure",
      mk(4'd5, 6'h12, 34'h0_0003_0000, 2'b00, 2'b10), 2, DC, 3);

    // Locked NAPOT entry without R
    csr(0, 1, 2, 32'h0001_0000);
    csr(1, 0, 2, 32'h98);
    run_req("lock_m_fetch",
      mk(4'd6, 6'h13, 34'h0_0004_0000, 2'b11, 2'b00), 3, IFU, 0);
    csr(1, 1, 2, 32'h0);
    run_req("lock_kept",
      mk(4'd7, 6'h14, 34'h0_0004_0000, 2'b11, 2'b00), 3, IFU, 0);

    // Reset while in CHECK
    @(posedge clk); #1;
    ptw_drive = 1'b1;
    ptw_data  = mk(4'd8, 6'h16, 34'h0_0020_0000, 2'b01, 2'b10);
    @(posedge clk); #1;
    ptw_drive = 1'b0;
    ptw_data  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_check",
        128'({ptw_free, dc_drive, ifu_drive, lsu_drive}),
        128'(4'b1000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (dc_drive | ifu_drive | lsu_drive | !ptw_free) seen++;
    end
    chk("rst_no_packet", 128'(seen), 128'(0));
    // Config cleared: lock gone, no entry matches
    run_req("post_rst_s_fetch",
      mk(4'd9, 6'h17, 34'h0_0004_0000, 2'b01, 2'b00), 4, IFU, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
